// File: rtl/trafik_pkg.sv
// Shared definitions for the pedestrian crossing controller: FSM encoding and
// default timing constants (also used by the LED sequencer).
package trafik_pkg;

  localparam int unsigned CLK_HZ              = 22_000_000;
  localparam int unsigned DEBOUNCE_CYCLES_DEF = CLK_HZ / 100;  // 10 ms
  localparam int unsigned COOLDOWN_CYCLES_DEF = CLK_HZ * 5;    // 5 s

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_PENDING  = 2'd1,
    ST_COOLDOWN = 2'd2
  } state_t;

endpackage

// File: rtl/buton_debounce.sv
// Two-flop synchronizer plus stable-run debounce for the crossing button;
// emits a one-cycle pulse on every accepted rising edge of the clean level.
module buton_debounce
  import trafik_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic btn_clean,
  output logic press_pulse
);

  localparam logic [31:0] DB_LAST = 32'(DEBOUNCE_CYCLES - 1);

  logic        sync1;
  logic        sync2;
  logic [31:0] db_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1       <= 1'b0;
      sync2       <= 1'b0;
      db_cnt      <= '0;
      btn_clean   <= 1'b0;
      press_pulse <= 1'b0;
    end else begin
      sync1       <= btn_raw;
      sync2       <= sync1;
      press_pulse <= 1'b0;
      // Any agreement with the current clean level restarts the stable run.
      if (sync2 == btn_clean) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_LAST) begin
        btn_clean   <= sync2;
        db_cnt      <= '0;
        press_pulse <= sync2;
      end else begin
        db_cnt <= db_cnt + 32'd1;
      end
    end
  end

endmodule

// File: rtl/yaya_istek.sv
// Pedestrian request front end: latches one debounced press until the
// sequencer acknowledges it, then blocks presses for a cooldown window.
//
// state       | meaning
// ------------+------------------------------------------------------
// ST_IDLE     | no request; next accepted press is latched
// ST_PENDING  | request latched, waiting for req_ack; presses merged
// ST_COOLDOWN | request served; presses and req_ack ignored
module yaya_istek
  import trafik_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int unsigned COOLDOWN_CYCLES = COOLDOWN_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  input  logic req_ack,
  output logic btn_clean,
  output logic press_pulse,
  output logic req_pending,
  output logic cooldown_active
);

  localparam logic [31:0] CD_LAST = 32'(COOLDOWN_CYCLES - 1);

  state_t      state_q;
  state_t      state_d;
  logic [31:0] cd_cnt;

  buton_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk        (clk),
    .rst        (rst),
    .btn_raw    (btn_raw),
    .btn_clean  (btn_clean),
    .press_pulse(press_pulse)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:     if (press_pulse) state_d = ST_PENDING;
      // Ack has priority over a coincident press, which is simply dropped.
      ST_PENDING:  if (req_ack) state_d = ST_COOLDOWN;
      ST_COOLDOWN: if (cd_cnt == CD_LAST) state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= ST_IDLE;
      cd_cnt          <= '0;
      req_pending     <= 1'b0;
      cooldown_active <= 1'b0;
    end else begin
      state_q         <= state_d;
      req_pending     <= (state_d == ST_PENDING);
      cooldown_active <= (state_d == ST_COOLDOWN);
      if (state_q == ST_PENDING && req_ack) begin
        cd_cnt <= '0;
      end else if (state_q == ST_COOLDOWN && state_d == ST_COOLDOWN) begin
        cd_cnt <= cd_cnt + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_yaya_istek.sv
// Directed bench for yaya_istek: expected output events (with cycle numbers)
// are queued by the stimulus and matched by an independent negedge monitor.
module tb_yaya_istek;

  localparam int unsigned DB = 4;
  localparam int unsigned CD = 10;

  logic clk = 1'b0;
  logic rst;
  logic btn_raw;
  logic req_ack;
  logic btn_clean;
  logic press_pulse;
  logic req_pending;
  logic cooldown_active;

  yaya_istek #(
    .DEBOUNCE_CYCLES(DB),
    .COOLDOWN_CYCLES(CD)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .btn_raw        (btn_raw),
    .req_ack        (req_ack),
    .btn_clean      (btn_clean),
    .press_pulse    (press_pulse),
    .req_pending    (req_pending),
    .cooldown_active(cooldown_active)
  );

  always #5 clk = ~clk;

  typedef enum int {
    EV_CLEAN_ON, EV_CLEAN_OFF, EV_PRESS, EV_REQ_ON, EV_REQ_OFF, EV_CD_ON, EV_CD_OFF
  } ev_kind_t;

  typedef struct {
    ev_kind_t kind;
    int       cyc;
  } ev_t;

  ev_t exp_q[$];
  int  cyc    = 0;
  int  checks = 0;
  int  errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic expect_ev(input ev_kind_t k, input int c);
    ev_t e;
    e.kind = k;
    e.cyc  = c;
    exp_q.push_back(e);
  endtask

  task automatic check_ev(input ev_kind_t k);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_event: saw %s at cycle %0d, required none", k.name(), cyc);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != k || e.cyc != cyc) begin
        errors++;
        $display("FAIL event_order: saw %s at cycle %0d, required %s at cycle %0d",
                 k.name(), cyc, e.kind.name(), e.cyc);
      end
    end
  endtask

  task automatic chk(input string name, input logic act, input logic req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %b, required %b (cycle %0d)", name, act, req, cyc);
    end
  endtask

  logic p_clean = 1'b0;
  logic p_req   = 1'b0;
  logic p_cd    = 1'b0;

  always @(negedge clk) begin
    if (btn_clean === 1'b1 && p_clean !== 1'b1) check_ev(EV_CLEAN_ON);
    if (btn_clean === 1'b0 && p_clean === 1'b1) check_ev(EV_CLEAN_OFF);
    if (press_pulse === 1'b1) check_ev(EV_PRESS);
    if (req_pending === 1'b1 && p_req !== 1'b1) check_ev(EV_REQ_ON);
    if (req_pending === 1'b0 && p_req === 1'b1) check_ev(EV_REQ_OFF);
    if (cooldown_active === 1'b1 && p_cd !== 1'b1) check_ev(EV_CD_ON);
    if (cooldown_active === 1'b0 && p_cd === 1'b1) check_ev(EV_CD_OFF);
    p_clean = btn_clean;
    p_req   = req_pending;
    p_cd    = cooldown_active;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic outputs_zero(input string tag);
    chk({tag, "_btn_clean"}, btn_clean, 1'b0);
    chk({tag, "_press_pulse"}, press_pulse, 1'b0);
    chk({tag, "_req_pending"}, req_pending, 1'b0);
    chk({tag, "_cooldown_active"}, cooldown_active, 1'b0);
  endtask

  // Clean press starting now: level accepted 6 edges later, request one after.
  task automatic press(input int hold, input int gap, input bit expect_req);
    int e;
    e = cyc;
    btn_raw = 1'b1;
    expect_ev(EV_CLEAN_ON, e + 6);
    expect_ev(EV_PRESS, e + 6);
    if (expect_req) expect_ev(EV_REQ_ON, e + 7);
    tick(hold);
    btn_raw = 1'b0;
    expect_ev(EV_CLEAN_OFF, e + hold + 6);
    tick(gap);
  endtask

  task automatic ack_and_wait();
    int s;
    s = cyc;
    expect_ev(EV_REQ_OFF, s + 1);
    expect_ev(EV_CD_ON, s + 1);
    expect_ev(EV_CD_OFF, s + 1 + CD);
    req_ack = 1'b1;
    tick(1);
    req_ack = 1'b0;
    tick(CD);
  endtask

  initial begin
    int s;
    rst     = 1'b1;
    btn_raw = 1'b1;
    req_ack = 1'b0;

    // Reset with the button already held high.
    tick(1);
    outputs_zero("reset");
    tick(2);
    rst = 1'b0;
    press(12, 8, 1'b1);

    // Extra presses while pending are merged, then acknowledged.
    repeat (3) press(8, 8, 1'b0);
    ack_and_wait();

    // Bounce 1,0,1,1,0 then steady high, then 3-cycle glitches both ways.
    s = cyc;
    expect_ev(EV_CLEAN_ON, s + 11);
    expect_ev(EV_PRESS, s + 11);
    expect_ev(EV_REQ_ON, s + 12);
    expect_ev(EV_CLEAN_OFF, s + 28);
    btn_raw = 1'b1; tick(1);
    btn_raw = 1'b0; tick(1);
    btn_raw = 1'b1; tick(2);
    btn_raw = 1'b0; tick(1);
    btn_raw = 1'b1; tick(10);
    btn_raw = 1'b0; tick(3);
    btn_raw = 1'b1; tick(4);
    btn_raw = 1'b0; tick(10);
    btn_raw = 1'b1; tick(3);
    btn_raw = 1'b0; tick(9);

    // Press landing mid-cooldown is ignored.
    s = cyc;
    expect_ev(EV_REQ_OFF, s + 2);
    expect_ev(EV_CD_ON, s + 2);
    expect_ev(EV_CLEAN_ON, s + 6);
    expect_ev(EV_PRESS, s + 6);
    expect_ev(EV_CD_OFF, s + 12);
    expect_ev(EV_CLEAN_OFF, s + 14);
    btn_raw = 1'b1; tick(1);
    req_ack = 1'b1; tick(1);
    req_ack = 1'b0; tick(6);
    btn_raw = 1'b0; tick(8);

    // Press landing in the final cooldown cycle is ignored too.
    press(8, 8, 1'b1);
    s = cyc;
    expect_ev(EV_REQ_OFF, s + 1);
    expect_ev(EV_CD_ON, s + 1);
    expect_ev(EV_CLEAN_ON, s + 10);
    expect_ev(EV_PRESS, s + 10);
    expect_ev(EV_CD_OFF, s + 11);
    expect_ev(EV_CLEAN_OFF, s + 18);
    req_ack = 1'b1; tick(1);
    req_ack = 1'b0; tick(3);
    btn_raw = 1'b1; tick(8);
    btn_raw = 1'b0; tick(8);
    press(8, 8, 1'b1);

    // Press pulse and ack in the same cycle: ack wins, no new request.
    s = cyc;
    expect_ev(EV_CLEAN_ON, s + 6);
    expect_ev(EV_PRESS, s + 6);
    expect_ev(EV_REQ_OFF, s + 7);
    expect_ev(EV_CD_ON, s + 7);
    expect_ev(EV_CLEAN_OFF, s + 14);
    expect_ev(EV_CD_OFF, s + 17);
    btn_raw = 1'b1; tick(6);
    req_ack = 1'b1; tick(1);
    req_ack = 1'b0; tick(1);
    btn_raw = 1'b0; tick(12);

    // Reset while pending drops the request.
    press(8, 8, 1'b1);
    s = cyc;
    expect_ev(EV_REQ_OFF, s + 1);
    rst = 1'b1; tick(1);
    outputs_zero("rst_pending");
    rst = 1'b0;
    press(8, 8, 1'b1);

    // Reset mid-cooldown with the button held high through it.
    s = cyc;
    expect_ev(EV_REQ_OFF, s + 1);
    expect_ev(EV_CD_ON, s + 1);
    req_ack = 1'b1; tick(1);
    req_ack = 1'b0; tick(2);
    btn_raw = 1'b1; tick(1);
    expect_ev(EV_CD_OFF, s + 5);
    rst = 1'b1; tick(1);
    outputs_zero("rst_cooldown");
    tick(1);
    rst = 1'b0;
    expect_ev(EV_CLEAN_ON, s + 12);
    expect_ev(EV_PRESS, s + 12);
    expect_ev(EV_REQ_ON, s + 13);
    expect_ev(EV_CLEAN_OFF, s + 20);
    tick(8);
    btn_raw = 1'b0; tick(8);

    tick(4);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL missing_events: %0d expected events never seen, required 0 (next %s at cycle %0d)",
               exp_q.size(), exp_q[0].kind.name(), exp_q[0].cyc);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/yaya_istek.md
# yaya_istek

Pedestrian-request front end for the traffic light controller. It synchronizes and debounces the raw crossing button and latches a single request. The request is held until the light sequencer acknowledges it, then further presses are blocked for a cooldown window. It sits directly upstream of the LED sequencer and delivers a clean, level `req_pending`.

## Interface

Parameters:

- `DEBOUNCE_CYCLES`, default 220_000 (10 ms at 22 MHz): consecutive stable cycles required to accept a button level change; must be ≥ 1.
- `COOLDOWN_CYCLES`, default 110_000_000 (5 s at 22 MHz): cycles after acknowledge during which presses are ignored; must be ≥ 1.

Ports:

- `clk` in 1: single system clock; all logic on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `btn_raw` in 1: asynchronous, bouncy button, active-high.
- `req_ack` in 1: from the sequencer; single-cycle pulse when it starts serving the crossing.
- `btn_clean` out 1: debounced button level.
- `press_pulse` out 1: one-cycle pulse on each accepted rising edge of `btn_clean`.
- `req_pending` out 1: request latched, awaiting `req_ack`.
- `cooldown_active` out 1: high while in COOLDOWN.

## Operation

- **Synchronizer:** two flip-flops, `sync1` then `sync2`, both reset to 0.
- **Debounce:**
  - 32-bit counter `db_cnt`.
  - If `sync2 == btn_clean`, `db_cnt` is set to 0.
  - Otherwise, if `db_cnt == DEBOUNCE_CYCLES-1`: set `btn_clean <= sync2` and `db_cnt <= 0`.
  - Otherwise increment `db_cnt`.
  - Any mismatch run shorter than `DEBOUNCE_CYCLES` is discarded.
- **press_pulse:** registered, set at the same edge where `btn_clean` goes 0→1, cleared the next edge. A falling edge produces no pulse.
- **FSM** (states IDLE, PENDING, COOLDOWN):
  - IDLE: `press_pulse` → PENDING. `req_ack` is ignored.
  - PENDING: `req_pending = 1`. `req_ack` → COOLDOWN, with `cd_cnt <= 0`. Further presses are merged (no effect).
  - COOLDOWN: `cd_cnt` increments every cycle. At `cd_cnt == COOLDOWN_CYCLES-1` → IDLE. Presses and `req_ack` are ignored.
- **Outputs:** `req_pending` and `cooldown_active` are registered decodes of the next state.
- **Boundary rules:**
  - `press_pulse` and `req_ack` in the same cycle while PENDING: ack wins → COOLDOWN; the press is dropped.
  - `press_pulse` in the final COOLDOWN cycle: dropped; the FSM enters IDLE without a request.
  - `btn_raw` held high through and after reset: `btn_clean` starts at 0, so one press is accepted after the normal debounce latency.
  - `rst` mid-PENDING or mid-COOLDOWN: returns to IDLE immediately and the pending request is lost.
- **Arithmetic:** `db_cnt` and `cd_cnt` are 32-bit unsigned. Use equality compares only; counters never wrap.

## Timing

- **Reset values** (after the first edge with `rst` = 1): `btn_clean=0`, `press_pulse=0`, `req_pending=0`, `cooldown_active=0`, `sync1=sync2=0`, `db_cnt=cd_cnt=0`, state IDLE.
- **Press latency:** `btn_raw` rises before edge 1, stays high, no bounce.
  - `sync2` = 1 after edge 2.
  - `btn_clean` = 1 and `press_pulse` = 1 after edge `DEBOUNCE_CYCLES+2`.
  - `req_pending` = 1 after edge `DEBOUNCE_CYCLES+3`.
- **Acknowledge:** `req_ack` sampled high at edge N → `req_pending` = 0 and `cooldown_active` = 1 after edge N.
- **Cooldown length:** `cooldown_active` stays high for exactly `COOLDOWN_CYCLES` cycles.
- **Throughput:** at most one request per acknowledge plus `COOLDOWN_CYCLES`.

## Structure

- **Shared package `trafik_pkg`:**
  - State encoding: IDLE=2'd0, PENDING=2'd1, COOLDOWN=2'd2.
  - `CLK_HZ` = 22_000_000 and cycle constants for the default timing, shared with the LED sequencer.
- **Sub-module `buton_debounce`:** synchronizer, debounce counter and `press_pulse` generation. Ports: `clk`, `rst`, `btn_raw`, `btn_clean`, `press_pulse`; parameter `DEBOUNCE_CYCLES`.
- **Top level:** the FSM and cooldown counter.

## Test plan

All scenarios use `DEBOUNCE_CYCLES=4`, `COOLDOWN_CYCLES=10`.

1. Reset, then a clean press held high from cycle 0 → `btn_clean` and a single-cycle `press_pulse` after edge 6; `req_pending=1` after edge 7; no second pulse while held.
2. Bounce pattern 1,0,1,1,0 on `btn_raw`, then steady 1 → no `press_pulse` during the bounce; exactly one pulse 6 edges after the steady level begins; 3-cycle glitches never change `btn_clean`.
3. PENDING, then three extra presses, then a `req_ack` pulse → `req_pending` drops on the ack edge; `cooldown_active` is high for exactly 10 cycles, then IDLE.
4. Press accepted during COOLDOWN, including in its last cycle → `req_pending` stays 0. The next press after IDLE is latched normally.
5. `press_pulse` and `req_ack` in the same cycle while PENDING → COOLDOWN entered, `req_pending=0`, no new request afterwards.
6. `rst` asserted mid-PENDING, and separately mid-COOLDOWN with `btn_raw` held high → all outputs 0 after the reset edge; after release, one press is accepted 6 edges later.
